// File: rtl/qam_pkg.sv
// qam_pkg: shared constants and PRBS-15 step function for the QAM symbol generator
package qam_pkg;
  localparam logic MODE_PATTERN = 1'b0;
  localparam logic MODE_PRBS = 1'b1;
  localparam logic [14:0] PRBS15_TAPS = 15'h6000;
  localparam logic [14:0] PRBS_SEED = 15'h7FFF;
  localparam logic [27:0] PAT_INIT_DEF = 28'h6CC1555;
  function automatic logic [14:0] prbs15_step(input logic [14:0] s);
    return {s[13:0], ^(s & PRBS15_TAPS)};
  endfunction
endpackage

// File: rtl/qam_bit_source.sv
// qam_bit_source: rotating pattern register and PRBS-15 (x^15+x^14+1), advanced one symbol at a time
// Ports: clock, reset (async active-low); i_advance steps the source chosen by i_sel;
// i_load loads pattern/seed (zero seed -> 7FFF); o_pat_sym/o_prbs_sym are the symbol-wide MSB slices.
module qam_bit_source
  import qam_pkg::*;
#(
  parameter int BITS_PER_SYM = 4,
  parameter int PAT_W = 28,
  parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(PAT_INIT_DEF)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_advance,
  input  logic                    i_sel,
  input  logic                    i_load,
  input  logic [PAT_W-1:0]        i_load_pattern,
  input  logic [14:0]             i_load_seed,
  output logic [BITS_PER_SYM-1:0] o_pat_sym,
  output logic [BITS_PER_SYM-1:0] o_prbs_sym
);
  logic [PAT_W-1:0] r_pat, w_pat_rot;
  logic [14:0] r_prbs, w_prbs_next;
  assign w_pat_rot = (r_pat << BITS_PER_SYM) | (r_pat >> (PAT_W - BITS_PER_SYM));
  // all BITS_PER_SYM shifts of the LFSR are unrolled into a single cycle
  always_comb begin
    w_prbs_next = r_prbs;
    for (int k = 0; k < BITS_PER_SYM; k++) w_prbs_next = prbs15_step(w_prbs_next);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pat <= PAT_INIT;
      r_prbs <= PRBS_SEED;
    end else if (i_load) begin
      r_pat <= i_load_pattern;
      r_prbs <= (i_load_seed == '0) ? PRBS_SEED : i_load_seed;
    end else if (i_advance) begin
      if (i_sel == MODE_PATTERN) r_pat <= w_pat_rot;
      else r_prbs <= w_prbs_next;
    end
  end
  assign o_pat_sym = r_pat[PAT_W-1 -: BITS_PER_SYM];
  assign o_prbs_sym = r_prbs[14 -: BITS_PER_SYM];
endmodule

// File: rtl/qam_symbol_gen.sv
// qam_symbol_gen: test-data source producing one QAM symbol every PERIOD rising edges of enable_cntr
// Ports: clock, reset (async active-low); enable_cntr count strobe (0->1 edges); period edges/symbol (0 as 1);
// mode 0=pattern 1=PRBS-15; load/load_pattern/load_seed reload sources; sym_bits/sym_i/sym_q/adat_ki symbol
// outputs; data_change one-cycle strobe with each new symbol.
module qam_symbol_gen
  import qam_pkg::*;
#(
  parameter int BITS_PER_SYM = 4,
  parameter int PAT_W = 28,
  parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(PAT_INIT_DEF),
  parameter int DIV_W = 11
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable_cntr,
  input  logic [DIV_W-1:0]          period,
  input  logic                      mode,
  input  logic                      load,
  input  logic [PAT_W-1:0]          load_pattern,
  input  logic [14:0]               load_seed,
  output logic [BITS_PER_SYM-1:0]   sym_bits,
  output logic [BITS_PER_SYM/2-1:0] sym_i,
  output logic [BITS_PER_SYM/2-1:0] sym_q,
  output logic                      adat_ki,
  output logic                      data_change
);
  if (PAT_W % BITS_PER_SYM != 0 || BITS_PER_SYM % 2 != 0 || BITS_PER_SYM < 2 || BITS_PER_SYM > 15) begin : g_bad_param
    $error("qam_symbol_gen: BITS_PER_SYM must be even, 2..15, and divide PAT_W");
  end
  logic r_old_en, r_mode_q, r_data_change;
  logic [DIV_W-1:0] r_cntr, w_last;
  logic w_rise, w_term;
  logic [BITS_PER_SYM-1:0] w_pat_sym, w_prbs_sym;
  assign w_rise = enable_cntr & ~r_old_en;
  assign w_last = (period == '0) ? '0 : period - DIV_W'(1);
  // >= rather than == so a period lowered mid-symbol ends it on the next rise instead of wrapping
  assign w_term = w_rise & (r_cntr >= w_last) & ~load;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_old_en <= 1'b0;
      r_cntr <= '0;
      r_mode_q <= MODE_PATTERN;
      r_data_change <= 1'b0;
    end else begin
      r_old_en <= enable_cntr;
      r_data_change <= w_term;
      if (load || w_term) begin
        r_cntr <= '0;
        r_mode_q <= mode;
      end else if (w_rise) r_cntr <= r_cntr + DIV_W'(1);
    end
  end
  // the source advanced is the one the new mode selects, so sym_bits changes together with r_mode_q
  qam_bit_source #(
    .BITS_PER_SYM(BITS_PER_SYM),
    .PAT_W(PAT_W),
    .PAT_INIT(PAT_INIT)
  ) u_src (
    .clock(clock),
    .reset(reset),
    .i_advance(w_term),
    .i_sel(mode),
    .i_load(load),
    .i_load_pattern(load_pattern),
    .i_load_seed(load_seed),
    .o_pat_sym(w_pat_sym),
    .o_prbs_sym(w_prbs_sym)
  );
  assign sym_bits = (r_mode_q == MODE_PRBS) ? w_prbs_sym : w_pat_sym;
  assign sym_i = sym_bits[BITS_PER_SYM-1 -: BITS_PER_SYM/2];
  assign sym_q = sym_bits[BITS_PER_SYM/2-1:0];
  assign adat_ki = sym_bits[BITS_PER_SYM-1];
  assign data_change = r_data_change;
endmodule

// File: tb/tb_qam_symbol_gen.sv
// tb_qam_symbol_gen: scoreboard bench for qam_symbol_gen with directed vectors
module tb_qam_symbol_gen;
  logic clock = 0, reset = 0, enable_cntr = 0, mode = 0, load = 0;
  logic [10:0] period = 11'd4;
  logic [27:0] load_pattern = '0;
  logic [14:0] load_seed = '0;
  logic [3:0] sym_bits;
  logic [1:0] sym_i, sym_q;
  logic adat_ki, data_change;
  int total = 0, bad = 0;
  logic [3:0] exp_q[$];
  logic [3:0] e;
  logic [14:0] m;
  logic [3:0] t2[7] = '{4'hC, 4'hC, 4'h1, 4'h5, 4'h5, 4'h5, 4'h6};
  qam_symbol_gen dut (
    .clock(clock), .reset(reset), .enable_cntr(enable_cntr), .period(period), .mode(mode),
    .load(load), .load_pattern(load_pattern), .load_seed(load_seed), .sym_bits(sym_bits),
    .sym_i(sym_i), .sym_q(sym_q), .adat_ki(adat_ki), .data_change(data_change)
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic pulse(input bit term, input logic [3:0] sym);
    @(negedge clock);
    if (term) exp_q.push_back(sym);
    enable_cntr = 1;
    @(negedge clock);
    enable_cntr = 0;
  endtask
  always @(negedge clock) begin
    if (data_change) begin
      if (exp_q.size() == 0) check("unexpected_data_change", 32'(sym_bits), 32'hFFFF);
      else begin
        e = exp_q.pop_front();
        check("sym_bits", 32'(sym_bits), 32'(e));
        check("sym_iq", 32'({sym_i, sym_q, adat_ki}), 32'({e[3:2], e[1:0], e[3]}));
      end
    end
  end
  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(negedge clock);
    check("rst_sym", 32'(sym_bits), 32'h6);
    check("rst_i", 32'(sym_i), 32'h1);
    check("rst_q", 32'(sym_q), 32'h2);
    check("rst_adat", 32'(adat_ki), 32'h0);
    check("rst_dc", 32'(data_change), 32'h0);
    reset = 1;
    pulse(0, 0);
    check("t1_sym_after1", 32'({sym_bits, sym_i, sym_q}), 32'({4'h6, 2'd1, 2'd2}));
    repeat (2) pulse(0, 0);
    pulse(1, 4'hC);
    repeat (3) pulse(0, 0);
    pulse(1, 4'hC);
    @(negedge clock);
    check("t1_hold", 32'(sym_bits), 32'hC);
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    reset = 1;
    period = 11'd1;
    for (int i = 0; i < 7; i++) pulse(1, t2[i]);
    period = 11'd2;
    pulse(0, 0);
    @(negedge clock);
    enable_cntr = 1;
    load = 1;
    load_pattern = 28'hABCDEF1;
    @(negedge clock);
    enable_cntr = 0;
    load = 0;
    check("t4_load_sym", 32'(sym_bits), 32'hA);
    check("t4_load_no_dc", 32'(data_change), 32'h0);
    pulse(0, 0);
    pulse(1, 4'hB);
    period = 11'd3;
    @(negedge clock);
    enable_cntr = 1;
    repeat (100) @(negedge clock);
    enable_cntr = 0;
    pulse(0, 0);
    pulse(1, 4'hC);
    period = 11'd10;
    repeat (5) pulse(0, 0);
    period = 11'd2;
    pulse(1, 4'hD);
    period = 11'd4;
    repeat (3) pulse(0, 0);
    @(negedge clock);
    #1 reset = 0;
    #1 check("t6_async_sym", 32'(sym_bits), 32'h6);
    check("t6_async_dc", 32'(data_change), 32'h0);
    @(negedge clock);
    reset = 1;
    repeat (3) pulse(0, 0);
    pulse(1, 4'hC);
    mode = 1;
    @(negedge clock);
    load = 1;
    load_seed = 15'h0000;
    @(negedge clock);
    load = 0;
    check("t3_seed_sym", 32'(sym_bits), 32'hF);
    period = 11'd1;
    m = 15'h7FFF;
    repeat (4096) begin
      repeat (4) m = {m[13:0], m[14] ^ m[13]};
      pulse(1, m[14:11]);
    end
    repeat (3) @(negedge clock);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
